// File: rtl/fsm_pkg.sv
// rtl/fsm_pkg.sv - shared FSM encodings and defaults for the button front end
package fsm_pkg;

  typedef enum logic [1:0] {
    RELEASED  = 2'd0,
    ARMING    = 2'd1,
    HELD      = 2'd2,
    DISARMING = 2'd3
  } debounce_state_t;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
  localparam int DEFAULT_SYNC_STAGES     = 2;

endpackage

// File: rtl/press_debouncer_if.sv
// rtl/press_debouncer_if.sv - raw button in, debounced level and edge pulses out
interface press_debouncer_if;

  logic ButtonRaw;
  logic Press;
  logic Release;
  logic Level;

  modport master (output ButtonRaw, input Press, input Release, input Level);
  modport slave  (input ButtonRaw, output Press, output Release, output Level);

endinterface

// File: rtl/sync_chain.sv
// rtl/sync_chain.sv - multi-flop synchroniser with async active-low clear
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ff <= '0;
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/press_debouncer.sv
// rtl/press_debouncer.sv - synchronise and debounce a push button, emit press/release pulses
module press_debouncer
  import fsm_pkg::*;
#(
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES) + 1
) (
  input  logic               clock,
  input  logic               reset_n,
  press_debouncer_if.slave   btn
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic            btn_s;
  debounce_state_t state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic            press_q, release_q, level_q;
  logic            press_nxt, release_nxt, level_nxt;

  sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (btn.ButtonRaw),
    .q       (btn_s)
  );

  // Outputs are registered alongside the state so they change only on the clock edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= RELEASED;
      cnt       <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      level_q   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      press_q   <= press_nxt;
      release_q <= release_nxt;
      level_q   <= level_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      RELEASED: begin
        if (btn_s) begin
          state_nxt = ARMING;
          cnt_nxt   = CNT_ONE;
        end
      end
      ARMING: begin
        if (!btn_s) begin
          state_nxt = RELEASED;
          cnt_nxt   = '0;
        end else if (cnt == CNT_MAX) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      HELD: begin
        if (!btn_s) begin
          state_nxt = DISARMING;
          cnt_nxt   = CNT_ONE;
        end
      end
      DISARMING: begin
        if (btn_s) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
        end else if (cnt == CNT_MAX) begin
          state_nxt = RELEASED;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = RELEASED;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Pulses fire on the qualifying transition only, so a held button never repeats.
  always_comb begin
    press_nxt   = (state == ARMING) && (state_nxt == HELD);
    release_nxt = (state == DISARMING) && (state_nxt == RELEASED);
    level_nxt   = (state_nxt == HELD) || (state_nxt == DISARMING);
  end

  assign btn.Press   = press_q;
  assign btn.Release = release_q;
  assign btn.Level   = level_q;

endmodule
